// File: rtl/pc_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pc_stack_ctrl
// Purpose  : Program-counter sequencer with a hardware return-address stack.
//            Handles jump, call and return redirects with a one-cycle squash
//            pulse after each taken redirect. Stack over/underflow raises a
//            sticky error flag.
// Options  : PC_STACK_HALT_EN - when defined, the cycle that raises stk_err
//            also enters a HALT state (pc frozen, requests ignored) that is
//            left only through rst.
// Revision : 1.0 - initial release
// ============================================================================
module pc_stack_ctrl #(
    parameter int AW    = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     jump1,
    input  logic                     ret1,
    input  logic                     push1,
    input  logic [AW-1:0]            target,
    output logic [AW-1:0]            pc,
    output logic                     jump2,
    output logic [$clog2(DEPTH):0]   sp,
    output logic                     stk_full,
    output logic                     stk_empty,
    output logic                     stk_err
);

    localparam int PW  = $clog2(DEPTH);
    localparam int SPW = PW + 1;
    localparam logic [SPW-1:0] c_SP_FULL = SPW'(DEPTH);
    localparam logic [SPW-1:0] c_SP_ONE  = SPW'(1);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t          r_state_q, w_state_d;
    logic [AW-1:0]   r_pc_q,    w_pc_d;
    logic            r_jump2_q, w_jump2_d;
    logic [SPW-1:0]  r_sp_q,    w_sp_d;
    logic            r_err_q,   w_err_d;
    logic            r_full_q,  r_empty_q;

    logic [AW-1:0]   r_stack_q [DEPTH];
    logic            w_push;
    logic [PW-1:0]   w_wr_idx;
    logic [PW-1:0]   w_rd_idx;
    logic [AW-1:0]   w_pc_inc;

    assign w_pc_inc = r_pc_q + AW'(1);
    assign w_wr_idx = r_sp_q[PW-1:0];
    // Low bits minus one also gives DEPTH-1 when the stack is full.
    assign w_rd_idx = r_sp_q[PW-1:0] - PW'(1);

    // Pick exactly one action per cycle: squash, return, call, jump, sequential.
    always_comb begin
        w_state_d = r_state_q;
        w_pc_d    = w_pc_inc;
        w_jump2_d = 1'b0;
        w_sp_d    = r_sp_q;
        w_err_d   = r_err_q;
        w_push    = 1'b0;
        if (r_state_q == ST_HALT) begin
            w_pc_d = r_pc_q;
        end else if (r_jump2_q) begin
            // Squash cycle: requests from the control unit are stale.
            w_pc_d = w_pc_inc;
        end else if (jump1 && ret1) begin
            if (r_sp_q != '0) begin
                w_pc_d    = r_stack_q[w_rd_idx];
                w_sp_d    = r_sp_q - c_SP_ONE;
                w_jump2_d = 1'b1;
            end else begin
                w_err_d = 1'b1;
`ifdef PC_STACK_HALT_EN
                w_state_d = ST_HALT;
`endif
            end
        end else if (jump1 && push1) begin
            if (r_sp_q != c_SP_FULL) begin
                w_push    = 1'b1;
                w_sp_d    = r_sp_q + c_SP_ONE;
                w_pc_d    = target;
                w_jump2_d = 1'b1;
            end else begin
                w_err_d = 1'b1;
`ifdef PC_STACK_HALT_EN
                // Halting on overflow freezes pc instead of taking the call.
                w_state_d = ST_HALT;
                w_pc_d    = r_pc_q;
`else
                w_pc_d    = target;
                w_jump2_d = 1'b1;
`endif
            end
        end else if (jump1) begin
            w_pc_d    = target;
            w_jump2_d = 1'b1;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= ST_RUN;
            r_pc_q    <= '0;
            r_jump2_q <= 1'b0;
            r_sp_q    <= '0;
            r_err_q   <= 1'b0;
            r_full_q  <= 1'b0;
            r_empty_q <= 1'b1;
        end else begin
            r_state_q <= w_state_d;
            r_pc_q    <= w_pc_d;
            r_jump2_q <= w_jump2_d;
            r_sp_q    <= w_sp_d;
            r_err_q   <= w_err_d;
            r_full_q  <= (w_sp_d == c_SP_FULL);
            r_empty_q <= (w_sp_d == '0);
        end
    end

    // Return-address storage; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_stack_q[w_wr_idx] <= w_pc_inc;
        end
    end

    assign pc        = r_pc_q;
    assign jump2     = r_jump2_q;
    assign sp        = r_sp_q;
    assign stk_full  = r_full_q;
    assign stk_empty = r_empty_q;
    assign stk_err   = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_stack_ctrl
// Purpose  : Directed vector bench for pc_stack_ctrl (AW=8, DEPTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_stack_ctrl;

    localparam int AW    = 8;
    localparam int DEPTH = 8;

    logic           clk = 1'b0;
    logic           rst, jump1, ret1, push1;
    logic [AW-1:0]  target;
    logic [AW-1:0]  pc;
    logic           jump2;
    logic [3:0]     sp;
    logic           stk_full, stk_empty, stk_err;

    int n_vec = 0;
    int n_mis = 0;

    pc_stack_ctrl #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .jump1     (jump1),
        .ret1      (ret1),
        .push1     (push1),
        .target    (target),
        .pc        (pc),
        .jump2     (jump2),
        .sp        (sp),
        .stk_full  (stk_full),
        .stk_empty (stk_empty),
        .stk_err   (stk_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r, j, rt, p;
        logic [7:0] t;
        logic [7:0] e_pc;
        logic       e_j2;
        int         e_sp;
        logic       e_err;
    } vec_t;

    vec_t tbl [32];

    logic       prev_j2 = 1'b0;
    logic [7:0] m_pc;
    logic [7:0] m_stk [$];

    // jump2 must never be high on two consecutive cycles.
    always @(negedge clk) begin
        if (rst === 1'b0 && prev_j2 === 1'b1 && jump2 === 1'b1) begin
            $display("FAIL jump2_back_to_back: got jump2=1 twice, need at most once");
            n_mis++;
        end
        prev_j2 <= jump2;
    end

    task automatic step(input logic r, input logic j, input logic rt,
                        input logic p, input logic [7:0] t);
        rst = r; jump1 = j; ret1 = rt; push1 = p; target = t;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            $display("FAIL %s: got %0h, need %0h", name, act, exp);
            n_mis++;
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] e_pc,
                           input logic e_j2, input int e_sp, input logic e_err);
        chk({tag, ".pc"},    int'(pc),        int'(e_pc));
        chk({tag, ".jump2"}, int'(jump2),     int'(e_j2));
        chk({tag, ".sp"},    int'(sp),        e_sp);
        chk({tag, ".full"},  int'(stk_full),  int'(e_sp == DEPTH));
        chk({tag, ".empty"}, int'(stk_empty), int'(e_sp == 0));
        chk({tag, ".err"},   int'(stk_err),   int'(e_err));
    endtask

    initial begin
        //         r  j  rt p  target  pc     j2 sp err
        tbl[0]  = '{1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0}; // reset
        tbl[1]  = '{0, 0, 0, 0, 8'h00, 8'h01, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 8'h00, 8'h02, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 8'h00, 8'h03, 0, 0, 0};
        tbl[4]  = '{0, 1, 0, 0, 8'h0F, 8'h0F, 1, 0, 0}; // jump
        tbl[5]  = '{0, 0, 0, 0, 8'h00, 8'h10, 0, 0, 0}; // squash
        tbl[6]  = '{0, 1, 0, 1, 8'h40, 8'h40, 1, 1, 0}; // call from 0x10
        tbl[7]  = '{0, 1, 0, 0, 8'h77, 8'h41, 0, 1, 0}; // jump ignored in squash
        tbl[8]  = '{0, 0, 0, 0, 8'h00, 8'h42, 0, 1, 0};
        tbl[9]  = '{0, 1, 1, 0, 8'h00, 8'h11, 1, 0, 0}; // return
        tbl[10] = '{0, 1, 1, 0, 8'h00, 8'h12, 0, 0, 0}; // ret in squash: no underflow
        tbl[11] = '{0, 0, 1, 0, 8'h00, 8'h13, 0, 0, 0}; // ret1 alone = sequential
        tbl[12] = '{0, 0, 0, 1, 8'h99, 8'h14, 0, 0, 0}; // push1 alone = sequential
        tbl[13] = '{0, 1, 0, 0, 8'hFE, 8'hFE, 1, 0, 0};
        tbl[14] = '{0, 0, 0, 0, 8'h00, 8'hFF, 0, 0, 0};
        tbl[15] = '{0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0}; // wrap
        tbl[16] = '{0, 1, 0, 0, 8'hFE, 8'hFE, 1, 0, 0};
        tbl[17] = '{0, 0, 0, 0, 8'h00, 8'hFF, 0, 0, 0};
        tbl[18] = '{0, 1, 0, 1, 8'h20, 8'h20, 1, 1, 0}; // call at 0xFF pushes 0x00
        tbl[19] = '{0, 0, 0, 0, 8'h00, 8'h21, 0, 1, 0};
        tbl[20] = '{0, 1, 1, 0, 8'h00, 8'h00, 1, 0, 0};
        tbl[21] = '{0, 0, 0, 0, 8'h00, 8'h01, 0, 0, 0};
        tbl[22] = '{1, 1, 0, 1, 8'h30, 8'h00, 0, 0, 0}; // rst beats call
        tbl[23] = '{0, 0, 0, 0, 8'h00, 8'h01, 0, 0, 0};
        tbl[24] = '{0, 1, 0, 1, 8'h50, 8'h50, 1, 1, 0}; // nested calls
        tbl[25] = '{0, 0, 0, 0, 8'h00, 8'h51, 0, 1, 0};
        tbl[26] = '{0, 1, 0, 1, 8'h60, 8'h60, 1, 2, 0};
        tbl[27] = '{0, 0, 0, 0, 8'h00, 8'h61, 0, 2, 0};
        tbl[28] = '{0, 1, 1, 0, 8'h00, 8'h52, 1, 1, 0};
        tbl[29] = '{0, 0, 0, 0, 8'h00, 8'h53, 0, 1, 0};
        tbl[30] = '{0, 1, 1, 0, 8'h00, 8'h02, 1, 0, 0};
        tbl[31] = '{0, 0, 0, 0, 8'h00, 8'h03, 0, 0, 0};

        rst = 1'b1; jump1 = 1'b0; ret1 = 1'b0; push1 = 1'b0; target = '0;
        #2;
        for (int i = 0; i < 32; i++) begin
            step(tbl[i].r, tbl[i].j, tbl[i].rt, tbl[i].p, tbl[i].t);
            chk_all($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_j2,
                    tbl[i].e_sp, tbl[i].e_err);
        end

        // Fill the stack with 8 calls, then overflow on the 9th.
        m_pc = 8'h03;
        for (int i = 0; i < DEPTH; i++) begin
            logic [7:0] t;
            t = 8'h80 + 8'(i * 8);
            step(0, 1, 0, 1, t);
            m_stk.push_back(m_pc + 8'h01);
            m_pc = t;
            chk_all($sformatf("call%0d", i), m_pc, 1'b1, i + 1, 1'b0);
            step(0, 0, 0, 0, 8'h00);
            m_pc = m_pc + 8'h01;
            chk_all($sformatf("call%0d_sq", i), m_pc, 1'b0, i + 1, 1'b0);
        end
        step(0, 1, 0, 1, 8'hF0);
`ifdef PC_STACK_HALT_EN
        chk_all("overflow", m_pc, 1'b0, DEPTH, 1'b1);
        step(0, 1, 1, 0, 8'h00);
        chk_all("halt_hold", m_pc, 1'b0, DEPTH, 1'b1);
`else
        chk_all("overflow", 8'hF0, 1'b1, DEPTH, 1'b1);
        step(0, 0, 0, 0, 8'h00);
        chk_all("overflow_sq", 8'hF1, 1'b0, DEPTH, 1'b1);
        step(0, 1, 1, 0, 8'h00);
        chk_all("ret_after_ovf", m_stk[DEPTH-1], 1'b1, DEPTH - 1, 1'b1);
`endif

        // Reset clears the sticky error; then underflow.
        step(1, 0, 0, 0, 8'h00);
        chk_all("err_reset", 8'h00, 1'b0, 0, 1'b0);
        step(0, 1, 1, 0, 8'h00);
        chk_all("underflow", 8'h01, 1'b0, 0, 1'b1);
        step(0, 0, 0, 0, 8'h00);
`ifdef PC_STACK_HALT_EN
        chk_all("underflow_halt", 8'h01, 1'b0, 0, 1'b1);
`else
        chk_all("err_sticky", 8'h02, 1'b0, 0, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_stack_ctrl.md
PC_STACK_CTRL -- requirements
Module: pc_stack_ctrl

Interface
REQ-001 Parameter AW, default 8: program-counter and return-address width in bits.
REQ-002 Parameter DEPTH, default 8: number of return-stack entries; power of two, at least 2.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 jump1  input  1  redirect request from the control unit.
REQ-006 ret1  input  1  return request; arrives together with jump1.
REQ-007 push1  input  1  call qualifier; a call is jump1 & push1 & ~ret1.
REQ-008 target  input  AW  jump/call destination address.
REQ-009 pc  output  AW  current program counter.
REQ-010 jump2  output  1  squash pulse fed back to the control unit; high for the cycle after a taken redirect.
REQ-011 sp  output  log2(DEPTH)+1  stack occupancy, range 0..DEPTH.
REQ-012 stk_full / stk_empty  output  1 each  sp==DEPTH / sp==0.
REQ-013 stk_err  output  1  sticky flag for overflow or underflow.

Function
REQ-014 Each cycle SHALL perform exactly one action, chosen in this priority order: rst, squash, return, call, jump, sequential.
REQ-015 Squash: when jump2==1, jump1, ret1 and push1 SHALL be ignored; pc <= pc+1; jump2 <= 0.
REQ-016 Return (ret1 & jump1, stack not empty): pc <= top entry; sp <= sp-1; jump2 <= 1.
REQ-017 Call (stack not full): entry[sp] <= pc+1 (mod 2^AW); sp <= sp+1; pc <= target; jump2 <= 1.
REQ-018 Jump (jump1 & ~ret1 & ~push1): pc <= target; jump2 <= 1; stack unchanged.
REQ-019 Sequential (no request): pc <= pc+1 (mod 2^AW); jump2 <= 0.
REQ-020 All pc arithmetic SHALL wrap modulo 2^AW; for AW=8, pc 0xFF increments to 0x00.
REQ-021 Underflow (return request while sp==0): stk_err <= 1; pc <= pc+1; jump2 <= 0; sp stays 0.
REQ-022 Overflow (call request while sp==DEPTH): stk_err <= 1; push dropped; pc <= target; jump2 <= 1; sp stays DEPTH.
REQ-023 ret1 without jump1 and push1 without jump1 SHALL be treated as sequential.
REQ-024 jump2 SHALL never be high for two consecutive cycles.
REQ-025 All outputs SHALL be registered; a redirect requested in cycle N appears on pc in cycle N+1.
REQ-026 stk_err SHALL clear only on rst.

Reset
REQ-027 While rst==1 at a clock edge: pc <= 0; sp <= 0; jump2 <= 0; stk_err <= 0; halt state cleared.
REQ-028 rst SHALL take priority over every request, including in the cycle a call or return is issued.
REQ-029 Stack entry contents need not reset; they SHALL never be read while sp==0.

Configuration
REQ-030 Macro PC_STACK_HALT_EN: when defined, the cycle that sets stk_err SHALL also enter HALT.
REQ-031 In HALT: pc frozen; jump2 = 0; all requests ignored; exit only via rst.
REQ-032 In HALT, the overflow case of REQ-022 SHALL NOT load target.
REQ-033 When PC_STACK_HALT_EN is undefined, REQ-021 and REQ-022 apply as written, with no HALT state.

Verification
REQ-034 Reset, then 3 idle cycles -> pc 0,1,2,3; jump2=0; sp=0; stk_empty=1.
REQ-035 At pc=0x10, pulse jump1+push1 with target=0x40 -> pc=0x40, sp=1, jump2=1 for one cycle; later jump1+ret1 -> pc=0x11, sp=0.
REQ-036 Hold jump1=1 while jump2=1 -> request ignored and pc increments; jump2 never high twice in a row.
REQ-037 Perform 9 calls with DEPTH=8 -> 9th sets stk_err, sp=8, and pc=target (or frozen if PC_STACK_HALT_EN is defined); ret at sp=0 -> stk_err=1, pc+1.
REQ-038 pc=0xFF sequential -> 0x00; call at 0xFF pushes 0x00.
REQ-039 Assert rst in the same cycle as a call -> pc=0, sp=0, jump2=0, stk_err=0.
